i2c_slave_regmap: RTL and testbench

//  Register-file stage sitting directly downstream of the I2C slave byte engine.

---
 rtl/i2c_slave_regmap.sv | 139 +++++++++++++
 tb/tb_i2c_slave_regmap.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regmap.sv
//==============================================================================
// Module : i2c_slave_regmap
// Brief  : Pointer-addressed register file behind an I2C slave byte engine,
//          with a host-side read/write port onto the same registers.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module i2c_slave_regmap #(
    parameter int          PTR_W     = 4,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_frame_start,
    input  logic             i_frame_rw,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_ready_n,
    output logic [7:0]       o_tx_data,
    input  logic             i_tx_next_n,
    input  logic [PTR_W-1:0] i_host_addr,
    input  logic             i_host_we,
    input  logic [7:0]       i_host_wdata,
    output logic [7:0]       o_host_rdata,
    output logic             o_wr_pulse,
    output logic [PTR_W-1:0] o_wr_addr,
    output logic [PTR_W-1:0] o_ptr
);

    localparam int c_NUM_REGS = 2**PTR_W;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_PTR = 2'd1,
        ST_WRITE    = 2'd2,
        ST_READ     = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_next;
    logic             w_i2c_we;
    logic             r_rx_prev;
    logic             r_tx_prev;
    logic             w_rx_evt;
    logic             w_tx_evt;
    logic [7:0]       r_regs [c_NUM_REGS];
    logic [7:0]       r_tx_data;
    logic             r_wr_pulse;
    logic [PTR_W-1:0] r_wr_addr;

    assign w_rx_evt = r_rx_prev & ~i_rx_ready_n;
    assign w_tx_evt = r_tx_prev & ~i_tx_next_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_rx_prev <= 1'b1;
            r_tx_prev <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_ptr     <= w_ptr_next;
            r_rx_prev <= i_rx_ready_n;
            r_tx_prev <= i_tx_next_n;
        end
    end

    // A new frame overrides any byte event landing in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_i2c_we     = 1'b0;
        if (i_frame_start) begin
            w_state_next = i_frame_rw ? ST_READ : ST_WAIT_PTR;
        end else begin
            case (r_state)
                ST_WAIT_PTR: begin
                    if (w_rx_evt) begin
                        w_ptr_next   = i_rx_data[PTR_W-1:0];
                        w_state_next = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (w_rx_evt) begin
                        w_i2c_we   = 1'b1;
                        w_ptr_next = r_ptr + PTR_W'(1);
                    end
                end
                ST_READ: begin
                    if (w_tx_evt) begin
                        w_ptr_next = r_ptr + PTR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // The I2C write is issued last so it wins a same-index collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else begin
            if (i_host_we) begin
                r_regs[i_host_addr] <= i_host_wdata;
            end
            if (w_i2c_we) begin
                r_regs[r_ptr] <= i_rx_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tx_data  <= RESET_VAL;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= '0;
        end else begin
            r_tx_data  <= r_regs[w_ptr_next];
            r_wr_pulse <= w_i2c_we;
            if (w_i2c_we) begin
                r_wr_addr <= r_ptr;
            end
        end
    end

    assign o_tx_data    = r_tx_data;
    assign o_host_rdata = r_regs[i_host_addr];
    assign o_wr_pulse   = r_wr_pulse;
    assign o_wr_addr    = r_wr_addr;
    assign o_ptr        = r_ptr;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_regmap.sv
//==============================================================================
// Module : tb_i2c_slave_regmap
// Brief  : Directed self-checking bench for i2c_slave_regmap.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_i2c_slave_regmap;

    logic       clk;
    logic       reset;
    logic       frame_start;
    logic       frame_rw;
    logic [7:0] rx_data;
    logic       rx_ready_n;
    logic [7:0] tx_data;
    logic       tx_next_n;
    logic [3:0] host_addr;
    logic       host_we;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata;
    logic       wr_pulse;
    logic [3:0] wr_addr;
    logic [3:0] ptr;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [3:0] pulse_q [$];

    i2c_slave_regmap #(.PTR_W(4), .RESET_VAL(8'h00)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_frame_start (frame_start),
        .i_frame_rw    (frame_rw),
        .i_rx_data     (rx_data),
        .i_rx_ready_n  (rx_ready_n),
        .o_tx_data     (tx_data),
        .i_tx_next_n   (tx_next_n),
        .i_host_addr   (host_addr),
        .i_host_we     (host_we),
        .i_host_wdata  (host_wdata),
        .o_host_rdata  (host_rdata),
        .o_wr_pulse    (wr_pulse),
        .o_wr_addr     (wr_addr),
        .o_ptr         (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every cycle wr_pulse is high logs one write address.
    always @(negedge clk) begin
        if (wr_pulse === 1'b1) pulse_q.push_back(wr_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
        host_addr = a;
        #1;
        chk(tag, {24'd0, host_rdata}, {24'd0, exp});
    endtask

    task automatic frame(input logic rw);
        @(posedge clk); #1;
        frame_start = 1'b1;
        frame_rw    = rw;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic hwe,
                           input logic [3:0] ha, input logic [7:0] hd);
        @(posedge clk); #1;
        rx_data    = b;
        rx_ready_n = 1'b0;
        host_we    = hwe;
        host_addr  = ha;
        host_wdata = hd;
        @(posedge clk); #1;
        rx_ready_n = 1'b1;
        host_we    = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_tx();
        @(posedge clk); #1;
        tx_next_n = 1'b0;
        @(posedge clk); #1;
        tx_next_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0; frame_start = 1'b0; frame_rw = 1'b0;
        rx_data = 8'h00; rx_ready_n = 1'b1; tx_next_n = 1'b1;
        host_addr = 4'h0; host_we = 1'b0; host_wdata = 8'h00;

        // Reset
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) rd($sformatf("rst_reg%0h", i), 4'(i), 8'h00);
        chk("rst_ptr", {28'd0, ptr}, 32'h0);
        chk("rst_tx", {24'd0, tx_data}, 32'h00);
        chk("rst_pulse", {31'd0, wr_pulse}, 32'd0);
        chk("rst_nowrite", pulse_q.size(), 32'd0);

        // Write burst
        frame(1'b0);
        send_rx(8'h03, 1'b0, 4'h0, 8'h00);
        send_rx(8'hAA, 1'b0, 4'h0, 8'h00);
        send_rx(8'hBB, 1'b0, 4'h0, 8'h00);
        rd("burst_reg3", 4'h3, 8'hAA);
        rd("burst_reg4", 4'h4, 8'hBB);
        chk("burst_ptr", {28'd0, ptr}, 32'h5);
        chk("burst_npulse", pulse_q.size(), 32'd2);
        if (pulse_q.size() == 2) begin
            chk("burst_addr0", {28'd0, pulse_q[0]}, 32'h3);
            chk("burst_addr1", {28'd0, pulse_q[1]}, 32'h4);
        end
        pulse_q.delete();

        // Pointer wrap
        frame(1'b0);
        send_rx(8'h0F, 1'b0, 4'h0, 8'h00);
        send_rx(8'h11, 1'b0, 4'h0, 8'h00);
        send_rx(8'h22, 1'b0, 4'h0, 8'h00);
        rd("wrap_regF", 4'hF, 8'h11);
        rd("wrap_reg0", 4'h0, 8'h22);
        chk("wrap_ptr", {28'd0, ptr}, 32'h1);
        chk("wrap_npulse", pulse_q.size(), 32'd2);
        pulse_q.delete();

        // Repeated-start read
        frame(1'b0);
        send_rx(8'h03, 1'b0, 4'h0, 8'h00);
        chk("rd_ptrbyte_nopulse", pulse_q.size(), 32'd0);
        frame(1'b1);
        @(posedge clk); #1;
        chk("rd_tx0", {24'd0, tx_data}, 32'hAA);
        chk("rd_ptr0", {28'd0, ptr}, 32'h3);
        send_tx();
        chk("rd_tx1", {24'd0, tx_data}, 32'hBB);
        chk("rd_ptr1", {28'd0, ptr}, 32'h4);
        send_tx();
        chk("rd_tx2", {24'd0, tx_data}, 32'h00);
        chk("rd_ptr2", {28'd0, ptr}, 32'h5);
        send_rx(8'h77, 1'b0, 4'h0, 8'h00);
        chk("rd_rx_ignored", pulse_q.size(), 32'd0);
        chk("rd_ptr_hold", {28'd0, ptr}, 32'h5);
        rd("rd_reg5", 4'h5, 8'h00);

        // Host/I2C collision
        frame(1'b0);
        send_rx(8'h04, 1'b0, 4'h0, 8'h00);
        send_rx(8'h66, 1'b1, 4'h4, 8'h55);
        rd("coll_same_reg4", 4'h4, 8'h66);
        frame(1'b0);
        send_rx(8'h04, 1'b0, 4'h0, 8'h00);
        send_rx(8'h66, 1'b1, 4'h7, 8'h55);
        rd("coll_diff_reg7", 4'h7, 8'h55);
        rd("coll_diff_reg4", 4'h4, 8'h66);
        chk("coll_npulse", pulse_q.size(), 32'd2);
        pulse_q.delete();

        // Abort by reset after pointer byte
        frame(1'b0);
        send_rx(8'h02, 1'b0, 4'h0, 8'h00);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_ptr", {28'd0, ptr}, 32'h0);
        rd("abort_reg2", 4'h2, 8'h00);
        send_rx(8'h99, 1'b0, 4'h0, 8'h00);
        chk("abort_nopulse", pulse_q.size(), 32'd0);
        chk("abort_ptr_idle", {28'd0, ptr}, 32'h0);
        rd("abort_reg0", 4'h0, 8'h00);
        send_tx();
        chk("abort_tx_ignored", {28'd0, ptr}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
